// File: rtl/seq_det_pkg.sv
// Shared definitions for the seq_detect_mealy serial pattern detector.
// Holds the phase encoding, the default pattern and the fill counter sizing helper.
package seq_det_pkg;

    // Phase of the detector. It is derived from the fill count.
    // FILL means history is still being gathered.
    // ARMED means every further valid bit can complete a match.
    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_ARMED = 1'b1
    } phase_e;

    // Pattern loaded at reset when the instance does not override it.
    localparam logic [2:0] DEFAULT_PATTERN = 3'b101;

    // Width of the fill counter, which counts 0..pat_w-1.
    function automatic int unsigned fill_width(input int unsigned pat_w);
        int unsigned w;
        w = $clog2(pat_w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter.
// Ports:
//   clk_i  - rising-edge clock
//   rst_ni - asynchronous active-low reset
//   inc_i  - count one match this cycle
//   clr_i  - synchronous clear; has priority over inc_i
//   cnt_o  - current count, which holds at all-ones
module seq_match_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_mealy.sv
// Mealy detector for a serial bit pattern, with the pattern and overlap mode loadable at run time.
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-low reset
//   x, x_valid  - serial data bit and its qualifier
//   cfg_load    - load cfg_pattern/cfg_overlap and flush the history
//   cfg_pattern - new pattern, MSB is the oldest bit
//   cfg_overlap - new mode, where 1 allows overlapping matches
//   cnt_clr     - synchronous clear of match_cnt
//   y           - combinational match in the cycle of the completing bit
//   y_q         - y delayed by one clock
//   match_cnt   - saturating number of matches
module seq_detect_mealy
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      FILL_W   = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              y_dly_q;

    phase_e            phase;
    logic [PAT_W-1:0]  window;

    assign phase  = (fill_q == FILL_MAX) ? PH_ARMED : PH_FILL;
    // The stored history followed by the incoming bit. This is the candidate for the compare.
    assign window = {hist_q, x};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= PATTERN;
            ovl_q   <= OVERLAP;
            hist_q  <= '0;
            fill_q  <= '0;
            y_dly_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_dly_q <= y;
        end
    end

    // Next-state logic
    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            // The bit in the load cycle is dropped. The stale history does not matter because fill restarts.
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = window[PAT_W-2:0];
            if (y && !ovl_q) begin
                fill_d = '0;
            end else if (phase == PH_FILL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        y = 1'b0;
        if (x_valid && !cfg_load && (phase == PH_ARMED) && (window == pat_q)) begin
            y = 1'b1;
        end
    end

    assign y_q = y_dly_q;

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (y),
        .clr_i  (cnt_clr),
        .cnt_o  (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy. It uses directed table vectors, hand-written corner sequences and
// random stimulus. All of them are checked against a queue-based reference model.
module tb_seq_detect_mealy;

    localparam int unsigned PAT_W = 3;

    logic             clk;
    logic             rst;
    logic             x;
    logic             x_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             y, y2;
    logic             y_q, y_q2;
    logic [7:0]       match_cnt;
    logic [1:0]       match_cnt2;

    int checks   = 0;
    int failures = 0;

    seq_detect_mealy #(
        .PAT_W   (PAT_W),
        .PATTERN (3'b101),
        .OVERLAP (1'b1),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .y           (y),
        .y_q         (y_q),
        .match_cnt   (match_cnt)
    );

    seq_detect_mealy #(
        .PAT_W   (PAT_W),
        .PATTERN (3'b101),
        .OVERLAP (1'b1),
        .CNT_W   (2)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .y           (y2),
        .y_q         (y_q2),
        .match_cnt   (match_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. It holds the valid bits seen since the last flush and compares the tail
    // against the pattern.
    bit             mq[$];
    logic [PAT_W-1:0] m_pat;
    bit             m_ovl;
    bit             m_yq;
    int             m_cnt8, m_cnt2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pat  = 3'b101;
        m_ovl  = 1'b1;
        m_yq   = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    function automatic bit model_y(input bit xb, input bit vb, input bit ld);
        logic [PAT_W-1:0] last;
        if (!vb || ld || (mq.size() < PAT_W - 1)) return 1'b0;
        for (int i = 0; i < PAT_W - 1; i++) last[PAT_W-1-i] = mq[i];
        last[0] = xb;
        return last == m_pat;
    endfunction

    task automatic model_update(input bit xb, input bit vb, input bit ld,
                                input logic [PAT_W-1:0] pat, input bit ovl, input bit clr,
                                input bit ey);
        if (ld) begin
            m_pat = pat;
            m_ovl = ovl;
            mq.delete();
        end else if (vb) begin
            if (ey && !m_ovl) begin
                mq.delete();
            end else begin
                mq.push_back(xb);
                if (mq.size() > PAT_W - 1) void'(mq.pop_front());
            end
        end
        m_yq = ey;
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (ey) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    // Drive one cycle of inputs and check against the model before the next rising edge.
    task automatic step(input bit xb, input bit vb, input bit ld,
                        input logic [PAT_W-1:0] pat, input bit ovl, input bit clr);
        bit ey;
        @(negedge clk);
        x = xb; x_valid = vb; cfg_load = ld; cfg_pattern = pat; cfg_overlap = ovl; cnt_clr = clr;
        #1;
        ey = model_y(xb, vb, ld);
        check("y", {31'd0, y}, {31'd0, ey});
        check("y_w2", {31'd0, y2}, {31'd0, ey});
        check("y_q", {31'd0, y_q}, {31'd0, m_yq});
        check("y_q_w2", {31'd0, y_q2}, {31'd0, m_yq});
        check("match_cnt", {24'd0, match_cnt}, m_cnt8);
        check("match_cnt_w2", {30'd0, match_cnt2}, m_cnt2);
        model_update(xb, vb, ld, pat, ovl, clr, ey);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        x = 1'b1; x_valid = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst_y", {31'd0, y}, 32'd0);
            check("rst_y_q", {31'd0, y_q}, 32'd0);
            check("rst_cnt", {24'd0, match_cnt}, 32'd0);
            @(negedge clk);
        end
        model_reset();
        rst = 1'b1;
        x_valid = 1'b0;
    endtask

    typedef struct {
        bit               x;
        bit               v;
        bit               ld;
        logic [PAT_W-1:0] pat;
        bit               ovl;
        bit               ey;
    } vec_t;

    vec_t tv[$];

    initial begin
        // Defaults with overlap: matches on the 3rd and 5th bits.
        tv.push_back('{1, 1, 0, 3'b000, 0, 0});
        tv.push_back('{0, 1, 0, 3'b000, 0, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 1});
        tv.push_back('{0, 1, 0, 3'b000, 0, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 1});
        tv.push_back('{0, 0, 0, 3'b000, 0, 0});
        tv.push_back('{0, 0, 0, 3'b000, 0, 0});
        // Non-overlap load. The bit in the load cycle is ignored.
        tv.push_back('{1, 1, 1, 3'b101, 0, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 0});
        tv.push_back('{0, 1, 0, 3'b000, 0, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 1});
        tv.push_back('{0, 1, 0, 3'b000, 0, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 0});
        // Overlap again, then valid gaps.
        tv.push_back('{0, 0, 1, 3'b101, 1, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 0});
        tv.push_back('{1, 0, 0, 3'b000, 0, 0});
        tv.push_back('{0, 1, 0, 3'b000, 0, 0});
        tv.push_back('{0, 0, 0, 3'b000, 0, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 1});
        // Build a partial "10". Then load 110 on a bit that would have completed 101.
        tv.push_back('{1, 1, 0, 3'b000, 0, 0});
        tv.push_back('{0, 1, 0, 3'b000, 0, 0});
        tv.push_back('{1, 1, 1, 3'b110, 1, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 0});
        tv.push_back('{1, 1, 0, 3'b000, 0, 0});
        tv.push_back('{0, 1, 0, 3'b000, 0, 1});

        x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
        cfg_overlap = 1'b0; cnt_clr = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].x, tv[i].v, tv[i].ld, tv[i].pat, tv[i].ovl, 1'b0);
            check("tab_y", {31'd0, y}, {31'd0, tv[i].ey});
        end
        // Five matches so far. The 2-bit counter has saturated.
        step(0, 0, 0, 3'b000, 0, 0);
        check("tab_cnt8", {24'd0, match_cnt}, 32'd5);
        check("tab_cnt2", {30'd0, match_cnt2}, 32'd3);

        // Reset mid-sequence discards the partial history.
        do_reset();
        step(1, 1, 0, 3'b000, 0, 0);
        step(0, 1, 0, 3'b000, 0, 0);
        do_reset();
        step(1, 1, 0, 3'b000, 0, 0);
        check("post_rst_y", {31'd0, y}, 32'd0);

        // Saturation and clear priority. Start from a fresh reset.
        do_reset();
        for (int i = 0; i < 11; i++) step(((i % 2) == 0), 1, 0, 3'b000, 0, 0);
        step(0, 1, 0, 3'b000, 0, 0);
        check("sat_cnt2", {30'd0, match_cnt2}, 32'd3);
        check("sat_cnt8", {24'd0, match_cnt}, 32'd5);
        step(1, 1, 0, 3'b000, 0, 1);
        check("clr_y", {31'd0, y}, 32'd1);
        step(0, 0, 0, 3'b000, 0, 0);
        check("clr_cnt2", {30'd0, match_cnt2}, 32'd0);
        check("clr_cnt8", {24'd0, match_cnt}, 32'd0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0),
                 PAT_W'($urandom),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 59) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
